// File: rtl/derandomizer_pkg.sv
// -----------------------------------------------------------------------------
// derandomizer_pkg
// Shared constants and helpers for the two-register (x/y) 18-bit sequence
// generator used by the derandomizer and its transmit-side counterpart.
//   X_INIT / Y_INIT   : load values of the x and y registers
//   *_FB_TAPS         : bits XORed to form the new MSB on each advance
//   *_R0/R1_TAPS      : bits XORed (across x and y) to form mask bits 0 / 1
//   state_t           : frame state {IDLE, RUN}
// -----------------------------------------------------------------------------
package derandomizer_pkg;

    localparam int PRS_W = 18;

    localparam logic [PRS_W-1:0] X_INIT = 18'h00001;
    localparam logic [PRS_W-1:0] Y_INIT = 18'h3FFFF;

    // x feedback: x[7] ^ x[0];  y feedback: y[10] ^ y[7] ^ y[5] ^ y[0]
    localparam logic [PRS_W-1:0] X_FB_TAPS = 18'h00081;
    localparam logic [PRS_W-1:0] Y_FB_TAPS = 18'h004A1;

    // mask bit 0: x[0] ^ y[0]
    localparam logic [PRS_W-1:0] X_R0_TAPS = 18'h00001;
    localparam logic [PRS_W-1:0] Y_R0_TAPS = 18'h00001;

    // mask bit 1: x[4,6,15] ^ y[5,6,8..15]
    localparam logic [PRS_W-1:0] X_R1_TAPS = 18'h08050;
    localparam logic [PRS_W-1:0] Y_R1_TAPS = 18'h0FF60;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One advance of a right-shifting register whose new MSB is the parity
    // of the tapped bits.
    function automatic logic [PRS_W-1:0] prs_step(input logic [PRS_W-1:0] v,
                                                  input logic [PRS_W-1:0] taps);
        return {^(v & taps), v[PRS_W-1:1]};
    endfunction

    // Two-bit symbol mask for a given generator state.
    function automatic logic [1:0] prs_mask(input logic [PRS_W-1:0] x,
                                            input logic [PRS_W-1:0] y);
        return {(^(x & X_R1_TAPS)) ^ (^(y & Y_R1_TAPS)),
                (^(x & X_R0_TAPS)) ^ (^(y & Y_R0_TAPS))};
    endfunction

endpackage

// File: rtl/derandomizer_prs_core.sv
// -----------------------------------------------------------------------------
// prs_core
// x/y sequence generator with load and advance controls; the mask of the
// current state is presented combinationally.  Usable unchanged on the
// transmit side.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (forces load values)
//   load       : return to the load state
//   advance    : step the generator one symbol
//                (load && advance -> state one step past the load state)
//   r[1:0]     : mask for the current state
// -----------------------------------------------------------------------------
module prs_core
    import derandomizer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    output logic [1:0] r
);

    logic [PRS_W-1:0] x_reg;
    logic [PRS_W-1:0] y_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= X_INIT;
            y_reg <= Y_INIT;
        end else if (load && advance) begin
            // Frame start: the k=0 symbol used the load-state mask, so the
            // register goes straight to the k=1 state.
            x_reg <= prs_step(X_INIT, X_FB_TAPS);
            y_reg <= prs_step(Y_INIT, Y_FB_TAPS);
        end else if (load) begin
            x_reg <= X_INIT;
            y_reg <= Y_INIT;
        end else if (advance) begin
            x_reg <= prs_step(x_reg, X_FB_TAPS);
            y_reg <= prs_step(y_reg, Y_FB_TAPS);
        end
    end

    assign r = prs_mask(x_reg, y_reg);

endmodule

// File: rtl/derandomizer.sv
// -----------------------------------------------------------------------------
// derandomizer
// Removes the x/y sequence mask from a framed stream of 2-bit symbols.
// One output register, one cycle of latency, full-throughput handshakes.
// Optional feature macro: DERANDOMIZER_LEN_CHECK_EN (enables o_sof_err).
// Parameters:
//   FRAME_SYMS : frame length in symbols (2..65535)
// Ports:
//   i_clk, i_rst_n    : clock, asynchronous active-low reset
//   i_valid / o_ready : upstream handshake; i_sof marks frame symbol 0
//   i_sym[1:0]        : randomized input symbol
//   o_valid / i_ready : downstream handshake
//   o_sym[1:0]        : derandomized symbol
//   o_sof / o_eof     : first / last symbol of an output frame
//   o_sof_err         : one-cycle pulse when a frame restarts mid-frame
// -----------------------------------------------------------------------------
module derandomizer
    import derandomizer_pkg::*;
#(
    parameter int FRAME_SYMS = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_sof,
    input  logic [1:0] i_sym,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [1:0] o_sym,
    output logic       o_sof,
    output logic       o_eof,
    output logic       o_sof_err
);

    localparam logic [15:0] LAST_K = 16'(FRAME_SYMS - 1);
    localparam logic [1:0]  R_LOAD = prs_mask(X_INIT, Y_INIT);

    state_t      state_reg, state_next;
    logic [15:0] count_reg, count_next;

    logic       o_valid_reg;
    logic [1:0] o_sym_reg, sym_next;
    logic       o_sof_reg, sof_next;
    logic       o_eof_reg, eof_next;
    logic       emit;

    logic       accept;
    logic       prs_load;
    logic       prs_advance;
    logic [1:0] r;

    // Output register is free when empty or being drained this cycle.
    assign o_ready = !o_valid_reg || i_ready;
    assign accept  = i_valid && o_ready;

    prs_core u_prs (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .load    (prs_load),
        .advance (prs_advance),
        .r       (r)
    );

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        prs_load    = 1'b0;
        prs_advance = 1'b0;
        emit        = 1'b0;
        sym_next    = o_sym_reg;
        sof_next    = o_sof_reg;
        eof_next    = o_eof_reg;
        if (accept) begin
            if (i_sof) begin
                // Frame start (also a restart from RUN): k=0 uses the load
                // state mask regardless of where the generator is. Since
                // FRAME_SYMS >= 2, symbol 0 is never the last one.
                emit        = 1'b1;
                sym_next    = i_sym ^ R_LOAD;
                sof_next    = 1'b1;
                eof_next    = 1'b0;
                prs_load    = 1'b1;
                prs_advance = 1'b1;
                count_next  = 16'd1;
                state_next  = RUN;
            end else if (state_reg == RUN) begin
                emit     = 1'b1;
                sym_next = i_sym ^ r;
                sof_next = 1'b0;
                eof_next = (count_reg == LAST_K);
                if (count_reg == LAST_K) begin
                    prs_load   = 1'b1;
                    count_next = 16'd0;
                    state_next = IDLE;
                end else begin
                    prs_advance = 1'b1;
                    count_next  = count_reg + 16'd1;
                end
            end
            // IDLE without i_sof: symbol is accepted and dropped.
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            count_reg   <= 16'd0;
            o_valid_reg <= 1'b0;
            o_sym_reg   <= 2'b00;
            o_sof_reg   <= 1'b0;
            o_eof_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (o_ready) begin
                o_valid_reg <= emit;
                if (emit) begin
                    o_sym_reg <= sym_next;
                    o_sof_reg <= sof_next;
                    o_eof_reg <= eof_next;
                end
            end
        end
    end

    assign o_valid = o_valid_reg;
    assign o_sym   = o_sym_reg;
    assign o_sof   = o_sof_reg;
    assign o_eof   = o_eof_reg;

`ifdef DERANDOMIZER_LEN_CHECK_EN
    logic sof_err_reg;

    // Registered with the restart symbol, so it lines up with its o_valid
    // on the first cycle that symbol is presented.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sof_err_reg <= 1'b0;
        end else begin
            sof_err_reg <= accept && i_sof && (state_reg == RUN);
        end
    end

    assign o_sof_err = sof_err_reg;
`else
    assign o_sof_err = 1'b0;
`endif

endmodule

// File: tb/tb_derandomizer.sv
// -----------------------------------------------------------------------------
// tb_derandomizer
// Directed bench for derandomizer with FRAME_SYMS = 16: table vectors for the
// start of a frame and idle discards, plus hand-written sequences for
// reset mid-frame, multi-frame recovery, downstream stall and mid-frame
// restart.
// -----------------------------------------------------------------------------
module tb_derandomizer;

    localparam int FS = 16;

`ifdef DERANDOMIZER_LEN_CHECK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic       o_ready;
    logic       i_sof;
    logic [1:0] i_sym;
    logic       o_valid;
    logic       i_ready;
    logic [1:0] o_sym;
    logic       o_sof;
    logic       o_eof;
    logic       o_sof_err;

    derandomizer #(.FRAME_SYMS(FS)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_sof     (i_sof),
        .i_sym     (i_sym),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sym     (o_sym),
        .o_sof     (o_sof),
        .o_eof     (o_eof),
        .o_sof_err (o_sof_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Transmit-side mask per frame position, built from the generator
    // equations written out bit by bit.
    logic [1:0] seq_mask [FS];

    typedef struct packed {
        logic       v;
        logic       sof;
        logic [1:0] sym;
        logic       e_valid;
        logic [1:0] e_sym;
        logic       e_sof;
        logic       e_eof;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [1:0] d);
        @(negedge clk);
        i_valid = v;
        i_sof   = s;
        i_sym   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input int idx);
        vec_t t;
        t = tbl[idx];
        step(t.v, t.sof, t.sym);
        $display("vec %0d: sof=%0d sym=%0d -> o_valid=%0d o_sym=%0d o_sof=%0d o_eof=%0d",
                 idx, t.sof, t.sym, o_valid, o_sym, o_sof, o_eof);
        check("vec_valid", o_valid, t.e_valid);
        if (t.e_valid) begin
            check("vec_sym", o_sym, t.e_sym);
            check("vec_sof", o_sof, t.e_sof);
            check("vec_eof", o_eof, t.e_eof);
        end else begin
            check("vec_ready", o_ready, 1);
        end
    endtask

    // Randomize one data symbol at frame position k, send it and check the
    // recovered data and framing one cycle later.
    task automatic xfer(input int k, input logic sof, input logic e_eof,
                        input logic e_err, output logic [1:0] d);
        d = 2'($urandom_range(0, 3));
        step(1'b1, sof, d ^ seq_mask[k]);
        $display("xfer k=%0d data=%0d -> o_valid=%0d o_sym=%0d o_sof=%0d o_eof=%0d o_sof_err=%0d",
                 k, d, o_valid, o_sym, o_sof, o_eof, o_sof_err);
        check("xfer_valid", o_valid, 1);
        check("xfer_sym", o_sym, d);
        check("xfer_sof", o_sof, sof);
        check("xfer_eof", o_eof, e_eof);
        check("xfer_sof_err", o_sof_err, e_err);
    endtask

    task automatic run_frame(input int k_from, input int k_to);
        logic [1:0] d;
        for (int k = k_from; k <= k_to; k++) begin
            xfer(k, k == 0, k == FS - 1, 1'b0, d);
        end
    endtask

    initial begin
        logic [17:0] mx;
        logic [17:0] my;
        logic [1:0]  d5;
        logic [1:0]  d6;
        logic [1:0]  dd;

        mx = 18'h00001;
        my = 18'h3FFFF;
        for (int k = 0; k < FS; k++) begin
            seq_mask[k] = {mx[4] ^ mx[6] ^ mx[15] ^ my[5] ^ my[6] ^ my[8] ^ my[9] ^ my[10]
                           ^ my[11] ^ my[12] ^ my[13] ^ my[14] ^ my[15],
                           mx[0] ^ my[0]};
            mx = {mx[7] ^ mx[0], mx[17:1]};
            my = {my[10] ^ my[7] ^ my[5] ^ my[0], my[17:1]};
        end

        // Hand-derived masks for k = 0..7: 0,1,1,1,1,3,1,3.
        //            v     sof   sym    e_valid e_sym e_sof e_eof
        tbl[0]  = {1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[1]  = {1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[2]  = {1'b1, 1'b0, 2'd3, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[3]  = {1'b1, 1'b0, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[4]  = {1'b1, 1'b0, 2'd2, 1'b1, 2'd3, 1'b0, 1'b0};
        tbl[5]  = {1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0};
        // after reset: three idle symbols dropped, then a fresh frame
        tbl[6]  = {1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[7]  = {1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[8]  = {1'b1, 1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[9]  = {1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[10] = {1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[11] = {1'b1, 1'b0, 2'd3, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[12] = {1'b1, 1'b0, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[13] = {1'b1, 1'b0, 2'd2, 1'b1, 2'd3, 1'b0, 1'b0};
        tbl[14] = {1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0};
        tbl[15] = {1'b1, 1'b0, 2'd3, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[16] = {1'b1, 1'b0, 2'd2, 1'b1, 2'd1, 1'b0, 1'b0};

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_sym   = 2'd0;
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_sym", o_sym, 0);
        check("rst_sof", o_sof, 0);
        check("rst_eof", o_eof, 0);
        check("rst_sof_err", o_sof_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", o_ready, 1);

        // Frame start, k = 0..5 held in the output register.
        for (int i = 0; i <= 5; i++) apply_vec(i);

        // Asynchronous reset while k=5 is held: output drops without a clock.
        #2;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        #1;
        $display("reset mid-frame: o_valid=%0d o_sym=%0d", o_valid, o_sym);
        check("midrst_valid", o_valid, 0);
        check("midrst_sym", o_sym, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready", o_ready, 1);

        // Idle discards, then a frame that reproduces the start sequence.
        for (int i = 6; i <= 16; i++) apply_vec(i);
        run_frame(8, FS - 1);
        step(1'b0, 1'b0, 2'd0);
        check("post_eof_valid", o_valid, 0);

        // Three back-to-back frames of random data.
        for (int f = 0; f < 3; f++) run_frame(0, FS - 1);
        step(1'b0, 1'b0, 2'd0);
        check("gap_valid", o_valid, 0);

        // Downstream stall of five cycles while k=5 is held.
        for (int k = 0; k <= 5; k++) xfer(k, k == 0, 1'b0, 1'b0, d5);
        d6 = 2'($urandom_range(0, 3));
        @(negedge clk);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_sof   = 1'b0;
        i_sym   = d6 ^ seq_mask[6];
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            $display("stall %0d: o_valid=%0d o_sym=%0d o_ready=%0d", c, o_valid, o_sym, o_ready);
            check("stall_valid", o_valid, 1);
            check("stall_sym", o_sym, d5);
            check("stall_ready", o_ready, 0);
        end
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        $display("release: o_valid=%0d o_sym=%0d", o_valid, o_sym);
        check("release_valid", o_valid, 1);
        check("release_sym", o_sym, d6);
        check("release_sof", o_sof, 0);
        run_frame(7, FS - 1);

        // Restart at k=7: no eof for the old frame, new frame completes.
        run_frame(0, 6);
        xfer(0, 1'b1, 1'b0, LEN_CHK, dd);
        run_frame(1, FS - 1);
        step(1'b0, 1'b0, 2'd0);
        check("end_valid", o_valid, 0);
        check("end_sof_err", o_sof_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/derandomizer.md
DERANDOMIZER -- requirements
Module: derandomizer

Interface
REQ-001 Parameter FRAME_SYMS, default 1024, frame length in 2-bit symbols (range 2..65535).
REQ-002 i_clk  input  1  single clock; all state on rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i_valid / o_ready  input / output  1 / 1  upstream symbol handshake; a transfer occurs when both are high.
REQ-005 i_sof  input  1  qualifies the accepted symbol as frame symbol 0.
REQ-006 i_sym  input  2  received randomized symbol.
REQ-007 o_valid / i_ready  output / input  1 / 1  downstream handshake.
REQ-008 o_sym  output  2  derandomized symbol.
REQ-009 o_sof / o_eof  output  1 / 1  first and last symbol of the output frame.
REQ-010 o_sof_err  output  1  one-cycle pulse: i_sof accepted while a frame is in progress (LEN_CHECK builds only).

Function
REQ-011 The sequence generator SHALL use x[17:0] and y[17:0].
REQ-012 On load, x SHALL be 18'h00001 and y SHALL be 18'h3FFFF.
REQ-013 On advance, x SHALL become {x[7]^x[0], x[17:1]} and y SHALL become {y[10]^y[7]^y[5]^y[0], y[17:1]}.
REQ-014 The per-symbol mask SHALL be r = {x[4]^x[6]^x[15]^y[5]^y[6]^y[8]^y[9]^y[10]^y[11]^y[12]^y[13]^y[14]^y[15], x[0]^y[0]}.
REQ-015 o_sym SHALL be i_sym XOR r, where r is the mask of the symbol's position k in its frame, with k=0 using the loaded state; there is no enable delay.
REQ-016 The state machine SHALL have two states, IDLE and RUN.
REQ-017 In IDLE, an accepted symbol with i_sof=0 SHALL be discarded, with no output and o_ready kept high.
REQ-018 In IDLE, an accepted symbol with i_sof=1 SHALL be output using the load-state mask, the generator SHALL advance from the load state, the count SHALL be set to 1, and the block SHALL enter RUN.
REQ-019 In RUN, each accepted symbol SHALL advance the generator and increment the count.
REQ-020 The symbol at count FRAME_SYMS-1 SHALL carry o_eof=1, and the block SHALL then return to IDLE with the count at 0.
REQ-021 Latency SHALL be one cycle: a single output register captures the accepted symbol.
REQ-022 o_ready SHALL equal !o_valid || i_ready, so there is no bubble under continuous flow.
REQ-023 While o_valid=1 and i_ready=0, o_sym, o_sof and o_eof SHALL hold stable, and the generator and count SHALL not advance.
REQ-024 i_sof accepted in RUN SHALL restart the frame: the symbol is treated as k=0 and o_sof=1.
REQ-025 A restart of the type in REQ-024 SHALL truncate the previous frame without emitting o_eof.
REQ-026 If FRAME_SYMS is reached on the same symbol as i_sof, i_sof SHALL win: the symbol is output with o_sof=1 and o_eof=0.

Reset
REQ-027 Reset assertion SHALL immediately force: state IDLE, count 0, x and y at the load values, o_valid=0, o_sym=0, o_sof=0, o_eof=0, o_sof_err=0.
REQ-028 o_ready SHALL be 1 from the first clock after reset deassertion.
REQ-029 Reset mid-frame SHALL discard the held output symbol and the partial frame.

Configuration
REQ-030 The macro DERANDOMIZER_LEN_CHECK_EN SHALL control the o_sof_err feature.
REQ-031 When DERANDOMIZER_LEN_CHECK_EN is defined, o_sof_err SHALL pulse for one cycle, concurrent with the restart symbol's o_valid, on any accepted i_sof in RUN.
REQ-032 When DERANDOMIZER_LEN_CHECK_EN is not defined, o_sof_err SHALL be tied to 0 and no detection logic SHALL be built.

Structure
REQ-033 Package derandomizer_pkg SHALL hold:
- X_INIT and Y_INIT;
- the tap masks for x feedback, y feedback and both mask bits;
- the state enum {IDLE, RUN}.
REQ-034 Sub-module prs_core SHALL hold x and y with the controls load and advance, and SHALL output r[1:0] combinationally.
REQ-035 prs_core SHALL be shareable with the transmit-side sequence generator.

Verification
REQ-036 Reset, then i_sof=1 with i_sym=00, then i_sym=00 -> o_sym=00 with o_sof=1, then o_sym=01.
REQ-037 Transmit-side sequence applied to random data over 3 frames with FRAME_SYMS=16 -> original data recovered; o_eof on every 16th symbol; o_sof on each first symbol.
REQ-038 i_ready=0 for 5 cycles mid-frame -> o_sym held stable and o_ready=0; after release, no symbol lost or duplicated and the mask sequence continues unbroken.
REQ-039 Three symbols with i_sof=0 in IDLE, then an i_sof frame -> the three are dropped and the frame output starts at o_sym=i_sym^00.
REQ-040 i_sof at k=7 of a 16-symbol frame (macro defined) -> o_sof_err pulses once, no o_eof for the old frame, and the new frame runs to completion.
REQ-041 i_rst_n low at k=5 with o_valid=1 -> o_valid drops immediately, and the next i_sof frame reproduces the sequence from REQ-036.
